// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared state encoding and framing constants for the instruction
//            memory loader. IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_W         = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CSUM   = 3'd6
`endif
   } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_pack.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pack
// Purpose  : Little-endian 4-byte word assembler; flags the byte completing a word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_pack
   import imem_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_rdy
);

   localparam int c_IDX_W = $clog2(BYTES_PER_WORD);

   logic [c_IDX_W-1:0] r_idx;
   logic [WORD_W-9:0]  r_sr;

   // Bytes enter at the top so the first byte ends up in bits [7:0].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx <= '0;
         r_sr  <= '0;
      end else if (i_clr) begin
         r_idx <= '0;
         r_sr  <= '0;
      end else if (i_en) begin
         r_sr  <= {i_byte, r_sr[WORD_W-9:8]};
         r_idx <= r_idx + c_IDX_W'(1);
      end
   end

   assign o_word     = {i_byte, r_sr};
   assign o_word_rdy = i_en && (r_idx == c_IDX_W'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a length-framed byte stream into instruction memory and
//            holds the CPU in reset until done. Option: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] c_DEPTH_A = (ADDR_W + 1)'(DEPTH);
   localparam logic [16:0]     c_DEPTH_L = 17'(DEPTH);

   state_t          r_state;
   logic [15:0]     r_len;
   logic [15:0]     r_count;
   logic [ADDR_W:0] r_addr;

   logic              w_xfer;
   logic              w_start_ok;
   logic              w_in_range;
   logic [15:0]       w_len;
   logic [WORD_W-1:0] w_word;
   logic              w_word_rdy;

   assign w_xfer     = rx_valid && rx_ready;
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_in_range = r_addr < c_DEPTH_A;
   assign w_len      = {rx_data, r_len[7:0]};

   imem_loader_pack #(
      .WORD_W     (WORD_W)
   ) u_pack (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_start_ok),
      .i_en       (w_xfer && (r_state == S_DATA)),
      .i_byte     (rx_data),
      .o_word     (w_word),
      .o_word_rdy (w_word_rdy)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] r_csum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_csum <= '0;
      end else if (w_start_ok) begin
         r_csum <= '0;
      end else if (w_xfer && (r_state != S_CSUM)) begin
         r_csum <= r_csum ^ rx_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_count   <= '0;
         r_addr    <= '0;
         rx_ready  <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state   <= S_LEN_LO;
                  rx_ready  <= 1'b1;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  r_addr    <= '0;
                  r_count   <= '0;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= rx_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= rx_data;
                  if ({1'b0, w_len} > c_DEPTH_L) begin
                     err <= 1'b1;
                  end
                  if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state   <= S_CSUM;
`else
                     r_state   <= S_DONE;
                     rx_ready  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
`endif
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_word_rdy) begin
                  r_state  <= S_WRITE;
                  rx_ready <= 1'b0;
                  wr_en    <= w_in_range;
                  if (w_in_range) begin
                     wr_addr <= r_addr[ADDR_W-1:0];
                     wr_data <= w_word;
                  end
               end
            end
            S_WRITE: begin
               // Address saturates at DEPTH so overflow words never alias low memory.
               if (w_in_range) begin
                  r_addr <= r_addr + 1'b1;
               end
               r_count <= r_count + 16'd1;
               if ((r_count + 16'd1) == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state   <= S_CSUM;
                  rx_ready  <= 1'b1;
`else
                  r_state   <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
`endif
               end else begin
                  r_state  <= S_DATA;
                  rx_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_state  <= S_DONE;
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  if (rx_data != r_csum) begin
                     err <= 1'b1;
                  end else begin
                     cpu_reset <= 1'b0;
                  end
               end
            end
`endif
            default: begin
               r_state  <= S_IDLE;
               rx_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
